// File: rtl/rstatus_commit_unit_pkg.sv
// Shared constants, FSM encoding and code-range helper for the $rstatus commit unit.
package rstatus_commit_unit_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SETX_W     = 27;
  localparam int unsigned NUM_CAUSES = 5;

  localparam int unsigned RS_ADDI = 1;
  localparam int unsigned RS_ADD  = 2;
  localparam int unsigned RS_SUB  = 3;
  localparam int unsigned RS_MUL  = 4;
  localparam int unsigned RS_DIV  = 5;

  typedef enum logic {
    RS_IDLE = 1'b0,
    RS_PEND = 1'b1
  } rs_state_e;

  function automatic logic code_in_range(input logic [DATA_W-1:0] code,
                                         input int unsigned lo,
                                         input int unsigned hi);
    return (code >= DATA_W'(lo)) && (code <= DATA_W'(hi));
  endfunction

endpackage

// File: rtl/rstatus_commit_unit_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module rstatus_commit_unit_sat_counter #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inc,
  output logic [COUNT_W-1:0] q
);

  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {COUNT_W{1'b1}})) begin
      cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/rstatus_commit_unit.sv
// Owns $rstatus: merges writeback-slot writes with mult/div exception completions,
// deferring a colliding mult/div code through a one-entry buffer.
module rstatus_commit_unit
  import rstatus_commit_unit_pkg::*;
#(
  parameter int unsigned COUNT_W = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wb_ovf,
  input  logic [DATA_W-1:0]             wb_code,
  input  logic                          setx_en,
  input  logic [SETX_W-1:0]             setx_val,
  input  logic                          rf_wr_en,
  input  logic [DATA_W-1:0]             rf_wr_data,
  input  logic                          md_done,
  input  logic                          md_exc,
  input  logic [DATA_W-1:0]             md_code,
  output logic [DATA_W-1:0]             rstatus,
  output logic                          bex_taken,
  output logic [NUM_CAUSES-1:0]         cause_onehot,
  output logic                          exc_pulse,
  output logic                          md_pend,
  output logic                          md_lost,
  output logic [NUM_CAUSES*COUNT_W-1:0] cause_cnt
);

  rs_state_e         state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] rstatus_q, rstatus_d;
  logic              exc_pulse_q, exc_pulse_d;
  logic              md_lost_q, md_lost_d;

  logic                  wb_evt;
  logic                  md_new;
  logic [DATA_W-1:0]     wb_val;
  logic                  wb_exc;
  logic                  cnt_en;
  logic [DATA_W-1:0]     cnt_code;
  logic [NUM_CAUSES-1:0] inc_vec;

  assign wb_evt = setx_en | rf_wr_en | wb_ovf;
  assign md_new = md_done & md_exc;

  // Writeback source select; only the overflow path is an exception commit.
  always_comb begin
    wb_val = wb_code;
    wb_exc = 1'b0;
    if (setx_en) begin
      wb_val = DATA_W'(setx_val);
    end else if (rf_wr_en) begin
      wb_val = rf_wr_data;
    end else if (wb_ovf) begin
      wb_exc = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    rstatus_d   = rstatus_q;
    exc_pulse_d = 1'b0;
    md_lost_d   = md_lost_q;
    cnt_en      = 1'b0;
    cnt_code    = '0;

    unique case (state_q)
      RS_IDLE: begin
        if (wb_evt) begin
          rstatus_d   = wb_val;
          exc_pulse_d = wb_exc;
          cnt_en      = wb_exc && code_in_range(wb_code, RS_ADDI, RS_SUB);
          cnt_code    = wb_code;
          if (md_new) begin
            buf_d   = md_code;
            state_d = RS_PEND;
          end
        end else if (md_new) begin
          rstatus_d   = md_code;
          exc_pulse_d = 1'b1;
          cnt_en      = code_in_range(md_code, RS_ADDI, RS_DIV);
          cnt_code    = md_code;
        end
      end
      RS_PEND: begin
        // Buffer already occupied: any fresh mult/div exception is lost.
        if (md_new) begin
          md_lost_d = 1'b1;
        end
        if (wb_evt) begin
          rstatus_d   = wb_val;
          exc_pulse_d = wb_exc;
          cnt_en      = wb_exc && code_in_range(wb_code, RS_ADDI, RS_SUB);
          cnt_code    = wb_code;
        end else begin
          rstatus_d   = buf_q;
          exc_pulse_d = 1'b1;
          cnt_en      = code_in_range(buf_q, RS_ADDI, RS_DIV);
          cnt_code    = buf_q;
          state_d     = RS_IDLE;
        end
      end
      default: state_d = RS_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RS_IDLE;
      buf_q       <= '0;
      rstatus_q   <= '0;
      exc_pulse_q <= 1'b0;
      md_lost_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      rstatus_q   <= rstatus_d;
      exc_pulse_q <= exc_pulse_d;
      md_lost_q   <= md_lost_d;
    end
  end

  always_comb begin
    inc_vec = '0;
    for (int unsigned k = 0; k < NUM_CAUSES; k++) begin
      inc_vec[k] = cnt_en && (cnt_code == DATA_W'(k + 1));
    end
  end

  for (genvar k = 0; k < NUM_CAUSES; k++) begin : g_cnt
    rstatus_commit_unit_sat_counter #(
      .COUNT_W (COUNT_W)
    ) u_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (inc_vec[k]),
      .q     (cause_cnt[k*COUNT_W +: COUNT_W])
    );
  end

  always_comb begin
    cause_onehot = '0;
    for (int unsigned k = 0; k < NUM_CAUSES; k++) begin
      cause_onehot[k] = (rstatus_q == DATA_W'(k + 1));
    end
  end

  assign rstatus   = rstatus_q;
  assign bex_taken = |rstatus_q;
  assign exc_pulse = exc_pulse_q;
  assign md_pend   = (state_q == RS_PEND);
  assign md_lost   = md_lost_q;

endmodule

// File: tb/tb_rstatus_commit_unit.sv
// Directed plus randomized bench for rstatus_commit_unit against a queue-based reference model.
module tb_rstatus_commit_unit;

  localparam int unsigned CW   = 8;
  localparam int unsigned NC   = 5;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wb_ovf = 1'b0;
  logic [31:0]   wb_code = '0;
  logic          setx_en = 1'b0;
  logic [26:0]   setx_val = '0;
  logic          rf_wr_en = 1'b0;
  logic [31:0]   rf_wr_data = '0;
  logic          md_done = 1'b0;
  logic          md_exc = 1'b0;
  logic [31:0]   md_code = '0;
  logic [31:0]   rstatus;
  logic          bex_taken;
  logic [NC-1:0] cause_onehot;
  logic          exc_pulse;
  logic          md_pend;
  logic          md_lost;
  logic [NC*CW-1:0] cause_cnt;

  int n_checks = 0;
  int n_errors = 0;

  rstatus_commit_unit #(.COUNT_W(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .wb_ovf       (wb_ovf),
    .wb_code      (wb_code),
    .setx_en      (setx_en),
    .setx_val     (setx_val),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_data   (rf_wr_data),
    .md_done      (md_done),
    .md_exc       (md_exc),
    .md_code      (md_code),
    .rstatus      (rstatus),
    .bex_taken    (bex_taken),
    .cause_onehot (cause_onehot),
    .exc_pulse    (exc_pulse),
    .md_pend      (md_pend),
    .md_lost      (md_lost),
    .cause_cnt    (cause_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural value, deferred-code queue (at most one), counts.
  logic [31:0] m_rs = '0;
  logic [31:0] m_q[$];
  bit          m_lost = 1'b0;
  bit          m_pulse = 1'b0;
  int          m_cnt[NC] = '{default: 0};
  int          m_qs;
  bit          m_exc, m_cnt_ok;

  always @(posedge clock) begin
    if (reset) begin
      m_rs = '0;
      m_q.delete();
      m_lost = 1'b0;
      m_pulse = 1'b0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      m_qs = m_q.size();
      m_exc = 1'b0;
      m_cnt_ok = 1'b0;
      if (setx_en) begin
        m_rs = {5'b0, setx_val};
      end else if (rf_wr_en) begin
        m_rs = rf_wr_data;
      end else if (wb_ovf) begin
        m_rs = wb_code;
        m_exc = 1'b1;
        m_cnt_ok = (wb_code >= 1) && (wb_code <= 3);
      end else if (m_qs > 0) begin
        m_rs = m_q.pop_front();
        m_exc = 1'b1;
        m_cnt_ok = (m_rs >= 1) && (m_rs <= 5);
      end else if (md_done && md_exc) begin
        m_rs = md_code;
        m_exc = 1'b1;
        m_cnt_ok = (m_rs >= 1) && (m_rs <= 5);
      end
      if (md_done && md_exc) begin
        if (m_qs > 0) m_lost = 1'b1;
        else if (setx_en || rf_wr_en || wb_ovf) m_q.push_back(md_code);
      end
      if (m_exc && m_cnt_ok && m_cnt[int'(m_rs) - 1] < CMAX)
        m_cnt[int'(m_rs) - 1]++;
      m_pulse = m_exc;
    end
  end

  // Compare every cycle outside reset, on the inactive edge.
  always @(negedge clock) begin
    if (!reset) begin
      chk("rstatus", 64'(rstatus), 64'(m_rs));
      chk("bex_taken", 64'(bex_taken), 64'(m_rs != 0));
      chk("cause_onehot", 64'(cause_onehot),
          (m_rs >= 1 && m_rs <= 5) ? (64'd1 << (m_rs - 1)) : 64'd0);
      chk("exc_pulse", 64'(exc_pulse), 64'(m_pulse));
      chk("md_pend", 64'(md_pend), 64'(m_q.size() != 0));
      chk("md_lost", 64'(md_lost), 64'(m_lost));
      for (int k = 0; k < NC; k++)
        chk($sformatf("cause_cnt[%0d]", k + 1), 64'(cause_cnt[k*CW +: CW]), 64'(m_cnt[k]));
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_in();
    wb_ovf = 0; wb_code = '0; setx_en = 0; setx_val = '0;
    rf_wr_en = 0; rf_wr_data = '0; md_done = 0; md_exc = 0; md_code = '0;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int cause);
    return cause_cnt[(cause - 1)*CW +: CW];
  endfunction

  initial begin
    clear_in();
    repeat (3) tick();
    reset = 0;
    tick();
    chk("reset rstatus", 64'(rstatus), 64'd0);
    chk("reset bex", 64'(bex_taken), 64'd0);
    chk("reset cnt", 64'(cause_cnt), 64'd0);
    chk("reset pend", 64'(md_pend), 64'd0);

    // Single sub overflow.
    wb_ovf = 1; wb_code = 32'd3;
    tick(); clear_in();
    chk("sub rstatus", 64'(rstatus), 64'd3);
    chk("sub onehot", 64'(cause_onehot), 64'b00100);
    chk("sub pulse", 64'(exc_pulse), 64'd1);
    chk("sub cnt", 64'(cnt_of(3)), 64'd1);
    tick();

    // Collision: add overflow with div exception.
    wb_ovf = 1; wb_code = 32'd2; md_done = 1; md_exc = 1; md_code = 32'd5;
    tick(); clear_in();
    chk("coll rs1", 64'(rstatus), 64'd2);
    chk("coll pend1", 64'(md_pend), 64'd1);
    tick();
    chk("coll rs2", 64'(rstatus), 64'd5);
    chk("coll pend2", 64'(md_pend), 64'd0);
    chk("coll add", 64'(cnt_of(2)), 64'd1);
    chk("coll div", 64'(cnt_of(5)), 64'd1);

    // PEND held across two setx cycles.
    wb_ovf = 1; wb_code = 32'd1; md_done = 1; md_exc = 1; md_code = 32'd4;
    tick(); clear_in();
    setx_en = 1; setx_val = 27'd9;
    tick();
    chk("setx rs a", 64'(rstatus), 64'd9);
    chk("setx pend a", 64'(md_pend), 64'd1);
    tick(); clear_in();
    chk("setx rs b", 64'(rstatus), 64'd9);
    tick();
    chk("setx late mul", 64'(rstatus), 64'd4);
    chk("setx mul cnt", 64'(cnt_of(4)), 64'd1);
    chk("setx addi cnt", 64'(cnt_of(1)), 64'd1);

    // Second mult/div exception while buffered is lost.
    rf_wr_en = 1; rf_wr_data = 32'h77; md_done = 1; md_exc = 1; md_code = 32'd5;
    tick(); clear_in();
    chk("lost rf", 64'(rstatus), 64'h77);
    md_done = 1; md_exc = 1; md_code = 32'd4;
    tick(); clear_in();
    chk("lost flag", 64'(md_lost), 64'd1);
    chk("lost buf commit", 64'(rstatus), 64'd5);
    chk("lost div cnt", 64'(cnt_of(5)), 64'd2);
    chk("lost mul cnt", 64'(cnt_of(4)), 64'd1);
    tick();
    chk("lost sticky", 64'(md_lost), 64'd1);

    // Saturation.
    wb_ovf = 1; wb_code = 32'd1;
    repeat (300) tick();
    clear_in();
    chk("sat addi", 64'(cnt_of(1)), 64'd255);

    // Reset while a code is buffered.
    wb_ovf = 1; wb_code = 32'd2; md_done = 1; md_exc = 1; md_code = 32'd4;
    tick(); clear_in();
    chk("rst pend", 64'(md_pend), 64'd1);
    reset = 1;
    tick();
    reset = 0;
    tick();
    chk("rst rstatus", 64'(rstatus), 64'd0);
    chk("rst pend0", 64'(md_pend), 64'd0);
    chk("rst lost", 64'(md_lost), 64'd0);
    chk("rst cnt", 64'(cause_cnt), 64'd0);
    tick();
    chk("rst no late", 64'(rstatus), 64'd0);

    // Randomized traffic, model-checked every cycle.
    for (int n = 0; n < 3000; n++) begin
      int r;
      clear_in();
      r = int'($urandom_range(0, 9));
      if (r < 2) setx_en = 1;
      else if (r < 4) rf_wr_en = 1;
      else if (r < 7) wb_ovf = 1;
      if ($urandom_range(0, 9) == 0) begin
        setx_en = setx_en | 1'($urandom);
        rf_wr_en = rf_wr_en | 1'($urandom);
        wb_ovf = wb_ovf | 1'($urandom);
      end
      wb_code = 32'($urandom_range(0, 4));
      setx_val = 27'($urandom_range(0, 40));
      rf_wr_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 6)) : $urandom;
      md_done = ($urandom_range(0, 2) == 0);
      md_exc = 1'($urandom);
      r = int'($urandom_range(0, 4));
      md_code = (r == 4) ? 32'd7 : ((r[0]) ? 32'd5 : 32'd4);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1;
        tick();
        reset = 0;
      end else begin
        tick();
      end
    end
    clear_in();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
